// File: rtl/bitpack_pkg.sv
// Shared types and constants for the BitPack control sequencer and its channel helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bitpack_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WADDR,
        S_WRESP,
        S_RADDR,
        S_RDATA,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_BRESP   = 2'd1;
    localparam logic [1:0] ERR_RRESP   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;

    // Completed-run counter that sticks at its maximum instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/axil_wr_chan.sv
// AXI-Lite AW/W handshake tracker: raises both VALIDs on launch, drops each on its own READY.
// Latency: VALIDs high the cycle after launch_i; both_o pulses combinationally in the cycle the last handshake completes.
// Backpressure: each VALID is held until its READY; launch_i must only be pulsed while idle.
module axil_wr_chan (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic launch_i,
    input  logic awready_i,
    input  logic wready_i,
    output logic awvalid_o,
    output logic wvalid_o,
    output logic both_o
);
    logic aw_q;
    logic w_q;
    logic active_q;

    // Both channels are done once each has either already handshaked or is handshaking now.
    assign both_o    = active_q && (!aw_q || awready_i) && (!w_q || wready_i);
    assign awvalid_o = aw_q;
    assign wvalid_o  = w_q;

    // Independent VALID tracking per channel; active_q marks a write in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            aw_q     <= 1'b0;
            w_q      <= 1'b0;
            active_q <= 1'b0;
        end else if (launch_i) begin
            aw_q     <= 1'b1;
            w_q      <= 1'b1;
            active_q <= 1'b1;
        end else begin
            if (aw_q && awready_i) aw_q <= 1'b0;
            if (w_q && wready_i)   w_q  <= 1'b0;
            if (both_o)            active_q <= 1'b0;
        end
    end

endmodule

// File: rtl/bitpack_ctrl_seq.sv
// AXI-Lite control master: replays a register-write script, polls a status register, repeats for several runs.
// Latency: first AW/W one cycle after START; each step waits on its slave handshake; ARVALID re-arms the cycle after a non-matching R.
// Backpressure: every VALID is held until READY; BREADY/RREADY are always high, so B and R are never stalled.
module bitpack_ctrl_seq #(
    parameter int unsigned ADDR_WIDTH  = 4,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned NUM_WRITES  = 4,
    parameter int unsigned ITERATIONS  = 2,
    parameter int unsigned RERUN_START = 3,
    parameter int unsigned POLL_ADDR   = 0,
    parameter logic [63:0] POLL_MASK   = 64'd1,
    parameter logic [63:0] POLL_VALUE  = 64'd0,
    parameter int unsigned TIMEOUT     = 65535
) (
    input  logic                             ACLK,
    input  logic                             ARESETN,
    input  logic                             START,
    input  logic [NUM_WRITES*ADDR_WIDTH-1:0] SCRIPT_ADDR,
    input  logic [NUM_WRITES*DATA_WIDTH-1:0] SCRIPT_DATA,
    output logic                             BUSY,
    output logic                             DONE,
    output logic                             ERROR,
    output logic [1:0]                       ERR_CODE,
    output logic [7:0]                       ITER,
    output logic [ADDR_WIDTH-1:0]            M_AWADDR,
    output logic [2:0]                       M_AWPROT,
    output logic                             M_AWVALID,
    input  logic                             M_AWREADY,
    output logic [DATA_WIDTH-1:0]            M_WDATA,
    output logic [DATA_WIDTH/8-1:0]          M_WSTRB,
    output logic                             M_WVALID,
    input  logic                             M_WREADY,
    input  logic [1:0]                       M_BRESP,
    input  logic                             M_BVALID,
    output logic                             M_BREADY,
    output logic [ADDR_WIDTH-1:0]            M_ARADDR,
    output logic [2:0]                       M_ARPROT,
    output logic                             M_ARVALID,
    input  logic                             M_ARREADY,
    input  logic [DATA_WIDTH-1:0]            M_RDATA,
    input  logic [1:0]                       M_RRESP,
    input  logic                             M_RVALID,
    output logic                             M_RREADY
);
    import bitpack_pkg::*;

    localparam int unsigned IDX_W = (NUM_WRITES > 1) ? $clog2(NUM_WRITES) : 1;
    localparam int unsigned PCW   = $clog2(TIMEOUT + 1);

    state_t                 state_q;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [PCW-1:0]         poll_q;
    logic [7:0]             iter_q;
    logic                   busy_q, done_q, error_q;
    logic [1:0]             err_code_q;
    logic [ADDR_WIDTH-1:0]  awaddr_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic                   arvalid_q;
    logic                   b_pend_q;
    logic [1:0]             b_resp_q;

    logic wr_both, b_hit, b_ok, r_ok, match, last_wr, last_run, poll_exp;
    logic start_go, next_wr, rerun, wr_launch;

    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign ERROR     = error_q;
    assign ERR_CODE  = err_code_q;
    assign ITER      = iter_q;
    assign M_AWADDR  = awaddr_q;
    assign M_AWPROT  = 3'b000;
    assign M_WDATA   = wdata_q;
    assign M_WSTRB   = {(DATA_WIDTH/8){1'b1}};
    assign M_BREADY  = 1'b1;
    assign M_ARADDR  = ADDR_WIDTH'(POLL_ADDR);
    assign M_ARPROT  = 3'b000;
    assign M_ARVALID = arvalid_q;
    assign M_RREADY  = 1'b1;

    axil_wr_chan u_wr_chan (
        .clk_i     (ACLK),
        .rst_ni    (ARESETN),
        .launch_i  (wr_launch),
        .awready_i (M_AWREADY),
        .wready_i  (M_WREADY),
        .awvalid_o (M_AWVALID),
        .wvalid_o  (M_WVALID),
        .both_o    (wr_both)
    );

    // Step decisions shared by the FSM and the write launcher; a B latched during WADDR counts as arrived.
    always_comb begin
        b_hit     = (state_q == S_WRESP) && (M_BVALID || b_pend_q);
        b_ok      = ((b_pend_q ? b_resp_q : M_BRESP) == RESP_OKAY);
        r_ok      = (M_RRESP == RESP_OKAY);
        match     = ((M_RDATA & POLL_MASK[DATA_WIDTH-1:0]) == POLL_VALUE[DATA_WIDTH-1:0]);
        last_wr   = (idx_q == IDX_W'(NUM_WRITES - 1));
        last_run  = ((32'(iter_q) + 32'd1) == ITERATIONS);
        poll_exp  = ((32'(poll_q) + 32'd1) >= TIMEOUT);
        start_go  = (state_q == S_IDLE) && START;
        next_wr   = b_hit && b_ok && !last_wr;
        rerun     = (state_q == S_RDATA) && M_RVALID && r_ok && match && !last_run;
        wr_launch = start_go || next_wr || rerun;
        idx_d     = idx_q;
        if (start_go)     idx_d = '0;
        else if (next_wr) idx_d = idx_q + IDX_W'(1);
        else if (rerun)   idx_d = IDX_W'(RERUN_START);
    end

    // Sequencer FSM with registered status outputs and script-entry capture on every write launch.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            poll_q     <= '0;
            iter_q     <= 8'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= ERR_NONE;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            arvalid_q  <= 1'b0;
            b_pend_q   <= 1'b0;
            b_resp_q   <= RESP_OKAY;
        end else begin
            idx_q <= idx_d;
            if (wr_launch) begin
                awaddr_q <= SCRIPT_ADDR[idx_d*ADDR_WIDTH +: ADDR_WIDTH];
                wdata_q  <= SCRIPT_DATA[idx_d*DATA_WIDTH +: DATA_WIDTH];
            end
            case (state_q)
                S_IDLE: begin
                    if (START) begin
                        state_q    <= S_WADDR;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        error_q    <= 1'b0;
                        err_code_q <= ERR_NONE;
                        iter_q     <= 8'd0;
                        poll_q     <= '0;
                    end
                end
                S_WADDR: begin
                    if (wr_both) begin
                        state_q <= S_WRESP;
                        // A B arriving with the final AW/W handshake is consumed by BREADY=1, so keep it.
                        if (M_BVALID) begin
                            b_pend_q <= 1'b1;
                            b_resp_q <= M_BRESP;
                        end
                    end
                end
                S_WRESP: begin
                    if (b_hit) begin
                        b_pend_q <= 1'b0;
                        if (!b_ok) begin
                            state_q    <= S_ERR;
                            busy_q     <= 1'b0;
                            error_q    <= 1'b1;
                            err_code_q <= ERR_BRESP;
                        end else if (!last_wr) begin
                            state_q <= S_WADDR;
                        end else begin
                            state_q   <= S_RADDR;
                            arvalid_q <= 1'b1;
                        end
                    end
                end
                S_RADDR: begin
                    if (M_ARREADY) begin
                        arvalid_q <= 1'b0;
                        state_q   <= S_RDATA;
                    end
                end
                S_RDATA: begin
                    if (M_RVALID) begin
                        if (!r_ok) begin
                            state_q    <= S_ERR;
                            busy_q     <= 1'b0;
                            error_q    <= 1'b1;
                            err_code_q <= ERR_RRESP;
                        end else if (match) begin
                            iter_q <= sat_inc8(iter_q);
                            poll_q <= '0;
                            if (last_run) begin
                                state_q <= S_DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= S_WADDR;
                            end
                        end else if (poll_exp) begin
                            state_q    <= S_ERR;
                            busy_q     <= 1'b0;
                            error_q    <= 1'b1;
                            err_code_q <= ERR_TIMEOUT;
                        end else begin
                            poll_q    <= poll_q + PCW'(1);
                            state_q   <= S_RADDR;
                            arvalid_q <= 1'b1;
                        end
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                S_ERR:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bitpack_ctrl_seq.sv
// Bench for bitpack_ctrl_seq: behavioural AXI-Lite slave, table vectors, hand sequences, randomized runs vs a run-level model.
// Latency: n/a.
// Backpressure: slave READY/B/R delays are configurable per run.
module tb_bitpack_ctrl_seq;

    localparam int NW  = 4;
    localparam int ITS = 2;
    localparam int RS  = 3;
    localparam int TMO = 8;

    logic         ACLK, ARESETN, START;
    logic [15:0]  SCRIPT_ADDR;
    logic [127:0] SCRIPT_DATA;
    logic         BUSY, DONE, ERROR;
    logic [1:0]   ERR_CODE;
    logic [7:0]   ITER;
    logic [3:0]   M_AWADDR, M_ARADDR;
    logic [2:0]   M_AWPROT, M_ARPROT;
    logic         M_AWVALID, M_AWREADY, M_WVALID, M_WREADY, M_BVALID, M_BREADY;
    logic [31:0]  M_WDATA, M_RDATA;
    logic [3:0]   M_WSTRB;
    logic [1:0]   M_BRESP, M_RRESP;
    logic         M_ARVALID, M_ARREADY, M_RVALID, M_RREADY;

    bitpack_ctrl_seq #(
        .ADDR_WIDTH(4), .DATA_WIDTH(32), .NUM_WRITES(NW), .ITERATIONS(ITS), .RERUN_START(RS),
        .POLL_ADDR(0), .POLL_MASK(64'd1), .POLL_VALUE(64'd0), .TIMEOUT(TMO)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .START(START),
        .SCRIPT_ADDR(SCRIPT_ADDR), .SCRIPT_DATA(SCRIPT_DATA),
        .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR), .ERR_CODE(ERR_CODE), .ITER(ITER),
        .M_AWADDR(M_AWADDR), .M_AWPROT(M_AWPROT), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
        .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
        .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
        .M_ARADDR(M_ARADDR), .M_ARPROT(M_ARPROT), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
        .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int total = 0;
    int bad   = 0;

    // slave configuration and observations
    int aw_d, w_d, b_d, ar_d, r_d, busy, werr, rerr;
    int n_aw, n_w, n_b, n_ar, rd_idx, rsw, viol;
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    bit aw_got, w_got, ar_got, aw_hs, w_hs;
    logic [3:0]  cap_a;
    logic [31:0] cap_d;
    logic [3:0]  wa_q[$];
    logic [31:0] wd_q[$];

    // script and model expectations
    logic [3:0]  sa[NW];
    logic [31:0] sd[NW];
    logic [3:0]  exp_wa[$];
    logic [31:0] exp_wd[$];
    int exp_rd, exp_code, exp_iter;

    typedef struct {
        int aw_d, w_d, b_d, busy, werr, rerr;
        int ex_done, ex_err, ex_code, ex_iter, ex_wr, ex_rd;
    } vec_t;
    vec_t tbl[11];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Behavioural slave: all driving and sampling on the falling edge.
    initial begin
        M_AWREADY = 0; M_WREADY = 0; M_BVALID = 0; M_BRESP = 0;
        M_ARREADY = 0; M_RVALID = 0; M_RRESP = 0; M_RDATA = 0;
        forever begin
            @(negedge ACLK);
            if (aw_hs && M_AWVALID) viol++;
            if (w_hs && M_WVALID) viol++;
            if (M_WVALID && M_WSTRB != 4'hF) viol++;
            if (M_AWPROT != 3'd0 || M_ARPROT != 3'd0 || !M_BREADY || !M_RREADY) viol++;
            if (M_ARVALID && M_ARADDR != 4'd0) viol++;
            aw_hs = 0; w_hs = 0;
            M_AWREADY = 0; M_WREADY = 0; M_BVALID = 0; M_ARREADY = 0; M_RVALID = 0;
            if (M_AWVALID && !aw_got) begin
                if (aw_cnt >= aw_d) begin M_AWREADY = 1; aw_got = 1; aw_hs = 1; cap_a = M_AWADDR; n_aw++; end
                else aw_cnt++;
            end
            if (M_WVALID && !w_got) begin
                if (w_cnt >= w_d) begin M_WREADY = 1; w_got = 1; w_hs = 1; cap_d = M_WDATA; n_w++; end
                else w_cnt++;
            end
            if (aw_got && w_got) begin
                if (b_cnt >= b_d) begin
                    M_BVALID = 1;
                    M_BRESP  = (n_b == werr) ? 2'b10 : 2'b00;
                    wa_q.push_back(cap_a); wd_q.push_back(cap_d);
                    n_b++; rsw = 0;
                    aw_got = 0; w_got = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
                end else b_cnt++;
            end
            if (ar_got) begin
                if (r_cnt >= r_d) begin
                    logic [31:0] rnd;
                    rnd = $urandom();
                    M_RVALID = 1;
                    M_RRESP  = (rd_idx == rerr) ? 2'b10 : 2'b00;
                    M_RDATA  = {rnd[31:1], (rsw < busy) ? 1'b1 : 1'b0};
                    rsw++; rd_idx++; ar_got = 0; r_cnt = 0;
                end else r_cnt++;
            end else if (M_ARVALID) begin
                if (ar_cnt >= ar_d) begin M_ARREADY = 1; ar_got = 1; n_ar++; ar_cnt = 0; end
                else ar_cnt++;
            end
        end
    end

    task automatic slave_clear();
        #1;
        n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; rd_idx = 0; rsw = 0; viol = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        aw_got = 0; w_got = 0; ar_got = 0; aw_hs = 0; w_hs = 0;
        wa_q.delete(); wd_q.delete();
    endtask

    task automatic pack_script();
        for (int i = 0; i < NW; i++) begin
            SCRIPT_ADDR[i*4 +: 4]   = sa[i];
            SCRIPT_DATA[i*32 +: 32] = sd[i];
        end
    endtask

    // Run-level model: writes come from the script order, reads follow the slave's status rule.
    task automatic model();
        int wr, polls;
        wr = 0;
        exp_wa.delete(); exp_wd.delete();
        exp_rd = 0; exp_code = 0; exp_iter = 0;
        for (int run = 0; run < ITS; run++) begin
            for (int i = (run == 0) ? 0 : RS; i < NW; i++) begin
                exp_wa.push_back(sa[i]); exp_wd.push_back(sd[i]);
                if (wr == werr) begin exp_code = 1; return; end
                wr++;
            end
            polls = 0;
            forever begin
                if (exp_rd == rerr) begin exp_rd++; exp_code = 2; return; end
                exp_rd++;
                if (polls >= busy) break;
                polls++;
                if (polls == TMO) begin exp_code = 3; return; end
            end
            exp_iter++;
        end
    endtask

    task automatic start_pulse();
        @(negedge ACLK); START = 1;
        @(negedge ACLK); START = 0;
    endtask

    task automatic wait_idle(input string tag, input bit poke);
        int cyc;
        cyc = 0;
        while (BUSY && cyc < 3000) begin
            @(negedge ACLK);
            START = poke && BUSY && (cyc % 9 == 4);
            cyc++;
        end
        START = 0;
        if (cyc >= 3000) begin
            total++; bad++;
            $display("FAIL %s.idle_timeout: actual=busy expected=idle", tag);
        end
        repeat (4) @(negedge ACLK);
    endtask

    task automatic check_run(input string tag, input int ex_done, input int ex_err,
                             input int ex_code, input int ex_iter, input int ex_wr, input int ex_rd);
        chk({tag, ".done"}, int'(DONE), ex_done);
        chk({tag, ".error"}, int'(ERROR), ex_err);
        chk({tag, ".err_code"}, int'(ERR_CODE), ex_code);
        chk({tag, ".iter"}, int'(ITER), ex_iter);
        chk({tag, ".busy"}, int'(BUSY), 0);
        chk({tag, ".n_aw"}, n_aw, ex_wr);
        chk({tag, ".n_w"}, n_w, ex_wr);
        chk({tag, ".n_b"}, n_b, ex_wr);
        chk({tag, ".n_ar"}, n_ar, ex_rd);
        chk({tag, ".protocol"}, viol, 0);
        chk({tag, ".wr_log_len"}, wa_q.size(), exp_wa.size());
        for (int i = 0; i < exp_wa.size() && i < wa_q.size(); i++) begin
            chk($sformatf("%s.awaddr%0d", tag, i), int'(wa_q[i]), int'(exp_wa[i]));
            chk($sformatf("%s.wdata%0d", tag, i), int'(wd_q[i]), int'(exp_wd[i]));
        end
    endtask

    initial begin
        int cyc;
        ARESETN = 0; START = 0;
        aw_d = 0; w_d = 0; b_d = 1; ar_d = 0; r_d = 0; busy = 4; werr = -1; rerr = -1;
        sa[0] = 4'hC; sa[1] = 4'h8; sa[2] = 4'h4; sa[3] = 4'h0;
        sd[0] = 32'h1000; sd[1] = 32'h400; sd[2] = 32'h0; sd[3] = 32'h1;
        pack_script();
        slave_clear();

        // aw_d w_d b_d busy werr rerr | done err code iter writes reads
        tbl[0]  = '{0, 0, 1,   4, -1, -1, 1, 0, 0, 2, 5, 10};
        tbl[1]  = '{0, 3, 1,   4, -1, -1, 1, 0, 0, 2, 5, 10};
        tbl[2]  = '{3, 0, 1,   4, -1, -1, 1, 0, 0, 2, 5, 10};
        tbl[3]  = '{1, 1, 0,   4, -1, -1, 1, 0, 0, 2, 5, 10};
        tbl[4]  = '{0, 0, 1,   4,  1, -1, 0, 1, 1, 0, 2, 0};
        tbl[5]  = '{0, 0, 1, 100, -1, -1, 0, 1, 3, 0, 4, 8};
        tbl[6]  = '{2, 1, 1,   4,  4, -1, 0, 1, 1, 1, 5, 5};
        tbl[7]  = '{0, 0, 1,   7, -1, -1, 1, 0, 0, 2, 5, 16};
        tbl[8]  = '{0, 0, 1,   8, -1, -1, 0, 1, 3, 0, 4, 8};
        tbl[9]  = '{0, 0, 0,   0, -1, -1, 1, 0, 0, 2, 5, 2};
        tbl[10] = '{0, 0, 1,   4, -1,  2, 0, 1, 2, 0, 4, 3};

        repeat (3) @(negedge ACLK);
        chk("reset.busy", int'(BUSY), 0);
        chk("reset.done", int'(DONE), 0);
        chk("reset.error", int'(ERROR), 0);
        chk("reset.err_code", int'(ERR_CODE), 0);
        chk("reset.iter", int'(ITER), 0);
        chk("reset.valids", int'({M_AWVALID, M_WVALID, M_ARVALID}), 0);
        chk("reset.readys", int'({M_BREADY, M_RREADY}), 3);
        chk("reset.wstrb", int'(M_WSTRB), 15);
        @(negedge ACLK); ARESETN = 1;

        for (int v = 0; v < 11; v++) begin
            aw_d = tbl[v].aw_d; w_d = tbl[v].w_d; b_d = tbl[v].b_d;
            busy = tbl[v].busy; werr = tbl[v].werr; rerr = tbl[v].rerr;
            slave_clear();
            model();
            start_pulse();
            wait_idle($sformatf("vec%0d", v), v == 0);
            check_run($sformatf("vec%0d", v), tbl[v].ex_done, tbl[v].ex_err, tbl[v].ex_code,
                      tbl[v].ex_iter, tbl[v].ex_wr, tbl[v].ex_rd);
        end

        // DONE is sticky in IDLE and clears on the next accepted START
        aw_d = 0; w_d = 0; b_d = 1; busy = 1; werr = -1; rerr = -1;
        slave_clear(); model();
        start_pulse();
        wait_idle("sticky", 0);
        chk("sticky.done_held", int'(DONE), 1);
        slave_clear(); model();
        start_pulse();
        chk("sticky.done_cleared", int'(DONE), 0);
        chk("sticky.busy_set", int'(BUSY), 1);
        wait_idle("sticky2", 0);
        check_run("sticky2", 1, 0, 0, 2, 5, 4);

        // asynchronous reset during the second poll, then a fresh replay from entry 0
        busy = 4;
        slave_clear(); model();
        start_pulse();
        cyc = 0;
        while (!(M_ARVALID && n_ar == 1) && cyc < 2000) begin
            @(posedge ACLK); #1; cyc++;
        end
        chk("rst.reached_poll2", int'(cyc < 2000), 1);
        #1 ARESETN = 0;
        #1;
        chk("rst.arvalid", int'(M_ARVALID), 0);
        chk("rst.aw_w_valid", int'({M_AWVALID, M_WVALID}), 0);
        chk("rst.busy", int'(BUSY), 0);
        chk("rst.flags", int'({DONE, ERROR, ERR_CODE}), 0);
        chk("rst.iter", int'(ITER), 0);
        repeat (2) @(negedge ACLK);
        slave_clear();
        @(negedge ACLK); ARESETN = 1;
        model();
        start_pulse();
        wait_idle("replay", 0);
        check_run("replay", 1, 0, 0, 2, 5, 10);

        // randomized scripts, slave timing and faults against the model
        for (int k = 0; k < 25; k++) begin
            for (int i = 0; i < NW; i++) begin
                sa[i] = 4'($urandom_range(0, 15));
                sd[i] = $urandom();
            end
            pack_script();
            aw_d = int'($urandom_range(0, 3)); w_d = int'($urandom_range(0, 3));
            b_d  = int'($urandom_range(0, 2)); ar_d = int'($urandom_range(0, 2));
            r_d  = int'($urandom_range(0, 2)); busy = int'($urandom_range(0, 9));
            werr = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 4)) : -1;
            rerr = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 12)) : -1;
            slave_clear();
            model();
            start_pulse();
            wait_idle($sformatf("rnd%0d", k), k % 3 == 0);
            check_run($sformatf("rnd%0d", k), (exp_code == 0) ? 1 : 0, (exp_code != 0) ? 1 : 0,
                      exp_code, exp_iter, exp_wa.size(), exp_rd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
